axi_rd_burst_checker: RTL and testbench

AXI4 read initiator that issues a programmed sequence of INCR read bursts and checks every returned beat against a constant expected word. It drives a read-only AXI4 slave port, either a memory or a constant-data responder, and is the traffic source and checker for read-path bring-up and loopback tests. It holds one burst outstanding at a time. It reports a beat count, an error count and a completion pulse.

---
 rtl/axi_rd_burst_checker_if.sv | 52 +++++
 rtl/axi_rd_burst_checker.sv | 180 ++++++++++++++++++
 tb/tb_axi_rd_burst_checker.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_burst_checker_if.sv
// AXI4 read-only channel bundle (AR + R) between the burst checker and a
// read responder. The checker is the master; the memory/responder is the slave.
interface axi_rd_burst_checker_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);

    // Read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;

    // Read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid,
        output araddr,
        output arlen,
        output arvalid,
        input  arready,
        input  rid,
        input  rdata,
        input  rresp,
        input  rlast,
        input  rvalid,
        output rready
    );

    modport slave (
        input  arid,
        input  araddr,
        input  arlen,
        input  arvalid,
        output arready,
        output rid,
        output rdata,
        output rresp,
        output rlast,
        output rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_burst_checker.sv
// AXI4 read burst initiator and checker. Issues a programmed number of INCR
// bursts back to back, one outstanding at a time, and compares every returned
// beat against a constant expected word, id, OKAY response and rlast position.
module axi_rd_burst_checker #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    ID_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] EXPECT_DATA = {DATA_WIDTH{1'b0}}
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,

    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [7:0]            cfg_len,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic [15:0]           cfg_num_bursts,

    output logic                  busy,
    output logic                  done,
    output logic [31:0]           beat_count,
    output logic [15:0]           err_count,

    axi_rd_burst_checker_if.master m_axi
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bytes per beat is a power of two, so the burst stride is a shift.
    localparam int LANES      = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(LANES);

    logic [1:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [7:0]            len_q,        len_d;
    logic [ID_WIDTH-1:0]   id_q,         id_d;
    logic [15:0]           remain_q,     remain_d;
    logic [7:0]            beat_idx_q,   beat_idx_d;
    logic [31:0]           beat_count_q, beat_count_d;
    logic [15:0]           err_count_q,  err_count_d;
    logic                  arvalid_q,    arvalid_d;
    logic                  rready_q,     rready_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;

    logic [LANES-1:0]      lane_mismatch;
    logic                  data_err;
    logic                  last_idx;
    logic                  beat_err;
    logic                  ar_fire;
    logic                  beat_fire;
    logic [ADDR_WIDTH-1:0] burst_bytes;

    // Per-byte-lane data compare; any differing lane flags the beat.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_mismatch[gi] = (m_axi.rdata[gi*8 +: 8] != EXPECT_DATA[gi*8 +: 8]);
        end
    endgenerate

    assign data_err  = |lane_mismatch;
    assign last_idx  = (beat_idx_q == len_q);
    assign ar_fire   = arvalid_q && m_axi.arready;
    assign beat_fire = (state_q == ST_DATA) && rready_q && m_axi.rvalid;

    // rlast must appear exactly on the beat whose index equals the programmed length.
    assign beat_err  = data_err
                    || (m_axi.rresp != 2'b00)
                    || (m_axi.rid != id_q)
                    || (m_axi.rlast != last_idx);

    // (len+1) beats times bytes per beat, truncated to the address width.
    assign burst_bytes = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << BEAT_SHIFT;

    // Next-state logic: sequencing of bursts, beat accounting and error counting.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        remain_d     = remain_q;
        beat_idx_d   = beat_idx_q;
        beat_count_d = beat_count_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = cfg_addr;
                    len_d        = cfg_len;
                    id_d         = cfg_id;
                    remain_d     = cfg_num_bursts;
                    beat_count_d = 32'd0;
                    err_count_d  = 16'd0;
                    state_d      = (cfg_num_bursts == 16'd0) ? ST_DONE : ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (ar_fire) begin
                    beat_idx_d = 8'd0;
                    state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (beat_fire) begin
                    beat_count_d = beat_count_q + 32'd1;
                    beat_idx_d   = beat_idx_q + 8'd1;
                    if (beat_err && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    // The burst ends on the length count, never on an early rlast.
                    if (last_idx) begin
                        remain_d = remain_q - 16'd1;
                        addr_d   = addr_q + burst_bytes;
                        state_d  = (remain_q == 16'd1) ? ST_DONE : ST_ADDR;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next state, so they line up
        // with the state they describe.
        arvalid_d = (state_d == ST_ADDR);
        rready_d  = (state_d == ST_DATA);
        busy_d    = (state_d == ST_ADDR) || (state_d == ST_DATA);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            remain_q     <= '0;
            beat_idx_q   <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            remain_q     <= remain_d;
            beat_idx_q   <= beat_idx_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign m_axi.arid    = id_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign beat_count = beat_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_axi_rd_burst_checker.sv
// Scoreboard bench for axi_rd_burst_checker: expected AR addresses and
// final counters are queued when a run is launched and popped when the DUT
// issues each AR and when it signals done.
`timescale 1ns/1ps
module tb_axi_rd_burst_checker;

    localparam int              DW  = 32;
    localparam int              AW  = 32;
    localparam int              IW  = 8;
    localparam logic [DW-1:0]   EXP = 32'hA5C3_0F96;

    logic            axi_clk = 1'b0;
    logic            axi_reset = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   cfg_addr = '0;
    logic [7:0]      cfg_len = '0;
    logic [IW-1:0]   cfg_id = '0;
    logic [15:0]     cfg_num_bursts = '0;
    logic            busy;
    logic            done;
    logic [31:0]     beat_count;
    logic [15:0]     err_count;

    axi_rd_burst_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_axi ();

    axi_rd_burst_checker #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .ID_WIDTH    (IW),
        .EXPECT_DATA (EXP)
    ) dut (
        .axi_clk        (axi_clk),
        .axi_reset      (axi_reset),
        .start          (start),
        .cfg_addr       (cfg_addr),
        .cfg_len        (cfg_len),
        .cfg_id         (cfg_id),
        .cfg_num_bursts (cfg_num_bursts),
        .busy           (busy),
        .done           (done),
        .beat_count     (beat_count),
        .err_count      (err_count),
        .m_axi          (m_axi)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] exp_ar_q[$];
    logic [47:0]   exp_res_q[$];   // {beats, errors}

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder stimulus for beat k of burst b under an error-injection mode.
    function automatic void beat_stim(input int mode, input int b, input int k,
                                      input logic [7:0] len, input logic [IW-1:0] id,
                                      output logic [DW-1:0] d, output logic [1:0] r,
                                      output logic [IW-1:0] i, output logic l);
        d = EXP;
        r = 2'b00;
        i = id;
        l = (k == int'(len));
        case (mode)
            1: begin
                if (b == 0 && k == 1) d = EXP ^ 32'h0000_0100;
                if (b == 0 && k == 2) begin
                    r = 2'b10;
                    i = id ^ 8'h01;
                end
            end
            2: if (b == 0) l = (k == 1);
            default: ;
        endcase
    endfunction

    task automatic run_seq(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                           input int nb, input int stall, input bit rnd, input int mode, input bit poke);
        int            exp_err;
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic [IW-1:0] i;
        logic          l;
        logic [AW-1:0] a0;
        logic [7:0]    l0;
        logic [IW-1:0] i0;
        logic [AW-1:0] exp_a;
        logic [47:0]   res;
        exp_err = 0;
        exp_ar_q.delete();
        exp_res_q.delete();
        for (int b = 0; b < nb; b++) begin
            exp_ar_q.push_back(addr + AW'(b * (int'(len) + 1) * (DW / 8)));
            for (int k = 0; k <= int'(len); k++) begin
                beat_stim(mode, b, k, len, id, d, r, i, l);
                if (d != EXP || r != 2'b00 || i != id || l != (k == int'(len))) exp_err++;
            end
        end
        exp_res_q.push_back({32'(nb * (int'(len) + 1)), 16'(exp_err)});

        @(negedge axi_clk);
        cfg_addr = addr;
        cfg_len = len;
        cfg_id = id;
        cfg_num_bursts = 16'(nb);
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
        cfg_addr = $urandom;
        cfg_len = 8'($urandom);
        cfg_id = 8'($urandom);
        cfg_num_bursts = 16'($urandom);

        if (nb == 0) begin
            check_value("zero_done", done, 1);
            check_value("zero_arvalid", m_axi.arvalid, 0);
            check_value("zero_busy", busy, 0);
            res = exp_res_q.pop_front();
            check_value("zero_beats", beat_count, res[47:16]);
            check_value("zero_errs", err_count, res[15:0]);
            @(negedge axi_clk);
            check_value("zero_done_pulse", done, 0);
            check_value("zero_arvalid_after", m_axi.arvalid, 0);
            $display("RUN addr=0x%08h bursts=0 beats=%0d errs=%0d", addr, beat_count, err_count);
            return;
        end

        check_value("start_arvalid", m_axi.arvalid, 1);
        check_value("start_busy", busy, 1);

        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 20 && !m_axi.arvalid; w++) @(negedge axi_clk);
            if (!m_axi.arvalid) begin
                check_value("ar_timeout", m_axi.arvalid, 1);
                return;
            end
            a0 = m_axi.araddr;
            l0 = m_axi.arlen;
            i0 = m_axi.arid;
            for (int s = 0; s < stall; s++) begin
                m_axi.arready = 1'b0;
                @(negedge axi_clk);
                check_value("ar_stable", {m_axi.arvalid, m_axi.araddr, m_axi.arlen, m_axi.arid},
                            {1'b1, a0, l0, i0});
            end
            m_axi.arready = 1'b1;
            @(negedge axi_clk);
            m_axi.arready = 1'b0;
            exp_a = exp_ar_q.pop_front();
            check_value("araddr", a0, exp_a);
            check_value("arlen", l0, len);
            check_value("arid", i0, id);
            $display("AR burst=%0d addr=0x%08h len=%0d id=0x%02h", b, a0, l0, i0);
            check_value("rready_after_ar", m_axi.rready, 1);
            check_value("single_outstanding", m_axi.arvalid, 0);

            for (int k = 0; k <= int'(len); k++) begin
                if (rnd) begin
                    for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                        m_axi.rvalid = 1'b0;
                        @(negedge axi_clk);
                    end
                end
                beat_stim(mode, b, k, len, id, d, r, i, l);
                m_axi.rvalid = 1'b1;
                m_axi.rdata = d;
                m_axi.rresp = r;
                m_axi.rid = i;
                m_axi.rlast = l;
                start = poke && (b == 0) && (k == 0);
                cfg_num_bursts = 16'd0;
                @(negedge axi_clk);
                start = 1'b0;
            end
            m_axi.rvalid = 1'b0;
            m_axi.rlast = 1'b0;
            if (b < nb - 1) begin
                check_value("next_ar_latency", m_axi.arvalid, 1);
            end else begin
                check_value("done_latency", done, 1);
                check_value("busy_drop", busy, 0);
            end
        end

        res = exp_res_q.pop_front();
        check_value("beat_count", beat_count, res[47:16]);
        check_value("err_count", err_count, res[15:0]);
        $display("RUN addr=0x%08h bursts=%0d beats=%0d errs=%0d", addr, nb, beat_count, err_count);
        @(negedge axi_clk);
        check_value("done_pulse", done, 0);
    endtask

    initial begin
        m_axi.arready = 1'b0;
        m_axi.rvalid = 1'b0;
        m_axi.rdata = '0;
        m_axi.rresp = 2'b00;
        m_axi.rid = '0;
        m_axi.rlast = 1'b0;

        // Reset values
        @(negedge axi_clk);
        @(negedge axi_clk);
        check_value("rst_outputs", {m_axi.arvalid, m_axi.rready, busy, done}, 4'b0000);
        check_value("rst_counts", {beat_count, err_count}, 48'd0);
        check_value("rst_ar_fields", {m_axi.araddr, m_axi.arid, m_axi.arlen}, 48'd0);
        axi_reset = 1'b0;
        @(negedge axi_clk);

        run_seq(32'h0000_1000, 8'd3, 8'h11, 1, 0, 1'b0, 0, 1'b0);   // single burst
        run_seq(32'h0000_0000, 8'd7, 8'h22, 3, 0, 1'b0, 0, 1'b0);   // multi-burst
        run_seq(32'h0000_0200, 8'd3, 8'h33, 1, 0, 1'b0, 1, 1'b0);   // data/resp/id errors
        run_seq(32'h0000_0300, 8'd3, 8'h44, 1, 0, 1'b0, 2, 1'b0);   // early rlast
        run_seq(32'h0000_0400, 8'd3, 8'h55, 0, 0, 1'b0, 0, 1'b0);   // zero bursts
        run_seq(32'h0000_0500, 8'd3, 8'h66, 2, 5, 1'b1, 0, 1'b1);   // backpressure + start while busy
        run_seq(32'hFFFF_FFF0, 8'd3, 8'h77, 2, 0, 1'b0, 0, 1'b0);   // address wrap

        // Reset in the middle of a data phase
        @(negedge axi_clk);
        cfg_addr = 32'h0000_8000;
        cfg_len = 8'd7;
        cfg_id = 8'h3C;
        cfg_num_bursts = 16'd2;
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
        m_axi.arready = 1'b1;
        @(negedge axi_clk);
        m_axi.arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_axi.rvalid = 1'b1;
            m_axi.rdata = EXP;
            m_axi.rresp = 2'b00;
            m_axi.rid = 8'h3C;
            m_axi.rlast = 1'b0;
            @(negedge axi_clk);
        end
        m_axi.rvalid = 1'b0;
        check_value("pre_reset_beats", beat_count, 2);
        check_value("pre_reset_rready", m_axi.rready, 1);
        #2 axi_reset = 1'b1;
        #1;
        check_value("async_rst_outputs", {m_axi.arvalid, m_axi.rready, busy, done}, 4'b0000);
        check_value("async_rst_counts", {beat_count, err_count}, 48'd0);
        check_value("async_rst_ar_fields", {m_axi.araddr, m_axi.arid, m_axi.arlen}, 48'd0);
        $display("RESET asserted mid-data");
        @(negedge axi_clk);
        axi_reset = 1'b0;
        @(negedge axi_clk);
        check_value("post_rst_idle", {m_axi.arvalid, busy}, 2'b00);

        run_seq(32'h0000_0600, 8'd1, 8'h88, 2, 1, 1'b1, 0, 1'b0);   // clean restart

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
